// File: rtl/wb_lfsr_sequencer_if.sv
// Wishbone link between the LFSR sequencer (master) and one wb_lfsr slave.
// Single-bit read data: the slave returns one LFSR output bit per read.
interface wb_lfsr_sequencer_if;
  logic       cyc;
  logic       stb;
  logic       we;
  logic [2:0] addr;
  logic [7:0] wdata;
  logic       stall;
  logic       ack;
  logic       rdata;

  modport master (
    output cyc, stb, we, addr, wdata,
    input  stall, ack, rdata
  );

  modport slave (
    input  cyc, stb, we, addr, wdata,
    output stall, ack, rdata
  );
endinterface

// File: rtl/wb_lfsr_sequencer.sv
// Wishbone master that brings up a wb_lfsr (reset, seed, load, run) and can
// then collect NUM_BITS output bits through single-bit reads.
//
// state    | meaning
// ---------+--------------------------------------------------------------
// S_IDLE   | waiting for i_start, bus idle
// S_REQ    | cyc=stb=1, command held until the slave takes it (stall=0)
// S_WAIT   | cyc=1, stb=0, waiting for ack with timeout
// S_GAP    | one cycle with cyc=0 between transactions
// S_DONE   | one-cycle o_done pulse, then back to idle
module wb_lfsr_sequencer #(
  parameter int          NUM_BITS     = 32,
  parameter logic [2:0]  READ_ADDR    = 3'b101,
  parameter int          ACK_TIMEOUT  = 255,
  parameter logic [31:0] DEFAULT_SEED = 32'h6424_0F15
) (
  input  logic                i_clk,
  input  logic                i_reset,
  input  logic                i_start,
  input  logic                i_sample_en,
  input  logic [31:0]         i_seed,
  output logic                o_busy,
  output logic                o_done,
  output logic                o_error,
  output logic [NUM_BITS-1:0] o_rand,
  wb_lfsr_sequencer_if.master wb
);

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_REQ  = 3'd1;
  localparam logic [2:0] S_WAIT = 3'd2;
  localparam logic [2:0] S_GAP  = 3'd3;
  localparam logic [2:0] S_DONE = 3'd4;

  localparam int TW = (ACK_TIMEOUT > 1) ? $clog2(ACK_TIMEOUT + 1) : 1;

  logic [2:0]    state;
  logic [6:0]    step;
  logic [31:0]   seed_q;
  logic          sample_q;
  logic [TW-1:0] tmo_cnt;

  logic [31:0] seed_in;
  logic [31:0] seed_nxt;
  logic [6:0]  step_nxt;
  logic [6:0]  last_step;
  logic        cmd_we;
  logic [2:0]  cmd_addr;
  logic [7:0]  cmd_data;
  logic        step_is_read;

  assign seed_in      = (i_seed == 32'd0) ? DEFAULT_SEED : i_seed;
  assign last_step    = sample_q ? 7'(6 + NUM_BITS) : 7'd6;
  assign step_is_read = (step >= 7'd7);

  // Command for the step about to be issued; from IDLE that is step 0 with
  // the incoming seed, since seed_q is only written on the same edge.
  always_comb begin
    step_nxt = (state == S_IDLE) ? 7'd0 : step + 7'd1;
    seed_nxt = (state == S_IDLE) ? seed_in : seed_q;
    cmd_we   = 1'b1;
    cmd_addr = 3'd4;
    cmd_data = 8'h00;
    case (step_nxt)
      7'd0: cmd_data = 8'h01;
      7'd1: begin cmd_addr = 3'd0; cmd_data = seed_nxt[7:0];   end
      7'd2: begin cmd_addr = 3'd1; cmd_data = seed_nxt[15:8];  end
      7'd3: begin cmd_addr = 3'd2; cmd_data = seed_nxt[23:16]; end
      7'd4: begin cmd_addr = 3'd3; cmd_data = seed_nxt[31:24]; end
      7'd5: cmd_data = 8'h02;
      7'd6: cmd_data = 8'h00;
      default: begin
        cmd_we   = 1'b0;
        cmd_addr = READ_ADDR;
        cmd_data = 8'h00;
      end
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state    <= S_IDLE;
      step     <= 7'd0;
      seed_q   <= 32'd0;
      sample_q <= 1'b0;
      tmo_cnt  <= '0;
      o_busy   <= 1'b0;
      o_done   <= 1'b0;
      o_error  <= 1'b0;
      o_rand   <= '0;
      wb.cyc   <= 1'b0;
      wb.stb   <= 1'b0;
      wb.we    <= 1'b0;
      wb.addr  <= 3'd0;
      wb.wdata <= 8'h00;
    end else begin
      o_done <= 1'b0;
      case (state)
        S_IDLE: begin
          if (i_start) begin
            seed_q   <= seed_in;
            sample_q <= i_sample_en;
            o_error  <= 1'b0;
            o_busy   <= 1'b1;
            step     <= step_nxt;
            wb.cyc   <= 1'b1;
            wb.stb   <= 1'b1;
            wb.we    <= cmd_we;
            wb.addr  <= cmd_addr;
            wb.wdata <= cmd_data;
            state    <= S_REQ;
          end
        end
        S_REQ: begin
          if (!wb.stall) begin
            wb.stb <= 1'b0;
            if (wb.ack) begin
              if (step_is_read)
                o_rand <= (o_rand << 1) | NUM_BITS'(wb.rdata);
              wb.cyc <= 1'b0;
              state  <= S_GAP;
            end else begin
              tmo_cnt <= TW'(ACK_TIMEOUT - 1);
              state   <= S_WAIT;
            end
          end
        end
        S_WAIT: begin
          if (wb.ack) begin
            if (step_is_read)
              o_rand <= (o_rand << 1) | NUM_BITS'(wb.rdata);
            wb.cyc <= 1'b0;
            state  <= S_GAP;
          end else if (tmo_cnt == '0) begin
            wb.cyc  <= 1'b0;
            o_error <= 1'b1;
            o_done  <= 1'b1;
            o_busy  <= 1'b0;
            state   <= S_DONE;
          end else begin
            tmo_cnt <= tmo_cnt - 1'b1;
          end
        end
        S_GAP: begin
          if (step == last_step) begin
            o_done <= 1'b1;
            o_busy <= 1'b0;
            state  <= S_DONE;
          end else begin
            // Entering the first read step starts a fresh sample word.
            if (step_nxt == 7'd7)
              o_rand <= '0;
            step     <= step_nxt;
            wb.cyc   <= 1'b1;
            wb.stb   <= 1'b1;
            wb.we    <= cmd_we;
            wb.addr  <= cmd_addr;
            wb.wdata <= cmd_data;
            state    <= S_REQ;
          end
        end
        S_DONE: state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
